sparce_skip_ctrl: RTL

Sequencing controller for the SparCE sparsity-skip path. It watches the fetch stream for instructions that hit in the SASA table and queries the sparsity register file for the tracked source registers. When the skip condition holds and no hazard invalidates it, it drives `skipping`/`sparce_target` toward fetch and hazard logic. It sits between the SASA table, the sparsity register file (SpRF) and the pipeline-facing SparCE interface, and keeps saturating skip/abort statistics.

---
 rtl/rv32i_types_pkg.sv | 6 +
 rtl/sparce_pkg.sv | 34 +++
 rtl/sparce_sat_counter.sv | 28 ++
 rtl/sparce_skip_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Basic RV32I datapath types shared across the core.
package rv32i_types_pkg;
  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/sparce_pkg.sv
// Shared SparCE types: controller states, skip-condition encoding, latched skip request.
package sparce_pkg;
  import rv32i_types_pkg::*;

  localparam int unsigned REG_W           = 5;
  localparam int unsigned SKIP_W          = 5;
  localparam int unsigned SPARCE_MAX_SKIP = 31;

  typedef logic [REG_W-1:0]  reg_addr_t;
  typedef logic [SKIP_W-1:0] skip_len_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SKIP  = 2'd2
  } sparce_ctrl_state_t;

  typedef enum logic {
    COND_RS1        = 1'b0,
    COND_RS1_OR_RS2 = 1'b1
  } sasa_cond_t;

  typedef struct packed {
    reg_addr_t  rs1;
    reg_addr_t  rs2;
    sasa_cond_t cond;
    word_t      target;
  } skip_req_t;

  // Redirect lands on the first instruction after the skipped block; wraps mod 2^32.
  function automatic word_t skip_target(input word_t pc, input skip_len_t insts);
    return pc + word_t'(4) + (word_t'(insts) << 2);
  endfunction
endpackage

// File: rtl/sparce_sat_counter.sv
// Saturating up-counter: an increment at all-ones leaves the value unchanged.
module sparce_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/sparce_skip_ctrl.sv
// SparCE skip sequencer: latches a SASA hit, checks SpRF sparsity for one cycle,
// then holds a registered redirect until fetch accepts it or a flush cancels it.
module sparce_skip_ctrl
  import rv32i_types_pkg::*;
  import sparce_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  word_t            pc,
  input  logic             if_ex_enable,
  input  logic             flush,
  input  logic             sasa_hit,
  input  logic [4:0]       sasa_insts,
  input  logic [4:0]       sasa_rs1,
  input  logic [4:0]       sasa_rs2,
  input  logic             sasa_cond,
  output logic [4:0]       sprf_rs1,
  output logic [4:0]       sprf_rs2,
  input  logic             rs1_zero,
  input  logic             rs2_zero,
  input  logic             wb_en,
  input  logic [4:0]       rd,
  output logic             skipping,
  output word_t            sparce_target,
  output logic [CNT_W-1:0] skip_cnt,
  output logic [CNT_W-1:0] abort_cnt
);
  sparce_ctrl_state_t state_q, state_d;
  skip_req_t          req_q, req_d;
  logic               skipping_q, skipping_d;
  word_t              target_q, target_d;
  logic               skip_inc, abort_inc;
  logic               rs1_kill, rs2_kill, cond_ok;

  // A writeback to a tracked register this cycle makes its sparsity bit stale.
  always_comb begin
    rs1_kill = wb_en && (rd == req_q.rs1) && (rd != '0);
    rs2_kill = wb_en && (rd == req_q.rs2) && (rd != '0);
    cond_ok  = (rs1_zero && !rs1_kill) ||
               ((req_q.cond == COND_RS1_OR_RS2) && rs2_zero && !rs2_kill);
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    skipping_d = skipping_q;
    target_d   = target_q;
    skip_inc   = 1'b0;
    abort_inc  = 1'b0;

    case (state_q)
      IDLE: begin
        if (sasa_hit && (sasa_insts != '0) && !flush) begin
          req_d.rs1    = sasa_rs1;
          req_d.rs2    = sasa_rs2;
          req_d.cond   = sasa_cond_t'(sasa_cond);
          req_d.target = skip_target(pc, sasa_insts);
          state_d      = CHECK;
        end
      end
      CHECK: begin
        // Advancing fetch means trigger+4 already left; too late to redirect.
        if (flush || if_ex_enable || !cond_ok) begin
          state_d   = IDLE;
          abort_inc = 1'b1;
        end else begin
          state_d    = SKIP;
          skipping_d = 1'b1;
          target_d   = req_q.target;
        end
      end
      SKIP: begin
        if (flush) begin
          state_d    = IDLE;
          skipping_d = 1'b0;
          target_d   = '0;
          abort_inc  = 1'b1;
        end else if (if_ex_enable) begin
          state_d    = IDLE;
          skipping_d = 1'b0;
          target_d   = '0;
          skip_inc   = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        skipping_d = 1'b0;
        target_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      req_q      <= '0;
      skipping_q <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      skipping_q <= skipping_d;
      target_q   <= target_d;
    end
  end

  sparce_sat_counter #(.W(CNT_W)) u_skip_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (skip_inc),
    .count (skip_cnt)
  );

  sparce_sat_counter #(.W(CNT_W)) u_abort_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (abort_inc),
    .count (abort_cnt)
  );

  assign sprf_rs1      = req_q.rs1;
  assign sprf_rs2      = req_q.rs2;
  assign skipping      = skipping_q;
  assign sparce_target = target_q;
endmodule
